// File: rtl/c4_sat.sv
// Saturating run counter with threshold/zero decodes, a one-shot pulse on reaching MAX,
// and an optional scan shift path that is built only when C4_SAT_SCAN_EN is defined.
module c4_sat #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned MAX    = 2,
  parameter int unsigned THRESH = 1
) (
  input  logic n_clk,
  input  logic rst,
  input  logic c,
  input  logic a,
  input  logic m,
  input  logic SDI,
  output logic s,
  output logic t,
  output logic n,
  output logic SDO
);

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] THRESH_V = WIDTH'(THRESH);

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("c4_sat: WIDTH must be in 1..16");
  end
  if (MAX < 1 || MAX > ((32'd1 << WIDTH) - 32'd1)) begin : g_bad_max
    $error("c4_sat: MAX must be in 1..2**WIDTH-1");
  end
  if (THRESH < 1 || THRESH > MAX) begin : g_bad_thresh
    $error("c4_sat: THRESH must be in 1..MAX");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_func;
  logic             t_func;
  logic             t_nxt;

  // Functional update: clear on a=0, otherwise count up and clamp at MAX
  always_comb begin
    cnt_func = '0;
    t_func   = 1'b0;
    if (a) begin
      if (cnt < MAX_V) begin
        cnt_func = WIDTH'(cnt + WIDTH'(1));
        t_func   = (cnt_func == MAX_V);
      end else begin
        cnt_func = MAX_V;
      end
    end
  end

`ifdef C4_SAT_SCAN_EN
  logic [WIDTH-1:0] cnt_shift;

  if (WIDTH == 1) begin : g_shift_w1
    assign cnt_shift = SDI;
  end else begin : g_shift_wn
    assign cnt_shift = {cnt[WIDTH-2:0], SDI};
  end

  always_comb begin
    cnt_nxt = cnt;
    t_nxt   = 1'b0;
    if (c) begin
      if (!m) begin
        cnt_nxt = cnt_shift;
      end else begin
        cnt_nxt = cnt_func;
        t_nxt   = t_func;
      end
    end
  end

  assign SDO = cnt[WIDTH-1];
`else
  logic unused_scan;
  assign unused_scan = m ^ SDI;

  always_comb begin
    cnt_nxt = cnt;
    t_nxt   = 1'b0;
    if (c) begin
      cnt_nxt = cnt_func;
      t_nxt   = t_func;
    end
  end

  assign SDO = 1'b0;
`endif

  always_ff @(posedge n_clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      t   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      t   <= t_nxt;
    end
  end

  assign s = (cnt >= THRESH_V);
  assign n = (cnt == '0);

endmodule

// File: tb/tb_c4_sat.sv
// Bench for c4_sat: directed scenarios plus random stimulus against an integer
// reference model; expectations follow C4_SAT_SCAN_EN the same way the design does.
module tb_c4_sat;

  localparam int W  = 2;
  localparam int MX = 2;
  localparam int TH = 1;

  logic n_clk;
  logic rst;
  logic c;
  logic a;
  logic m;
  logic SDI;
  logic s;
  logic t;
  logic n;
  logic SDO;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int mcnt = 0;
  bit mt   = 1'b0;

  c4_sat #(.WIDTH(W), .MAX(MX), .THRESH(TH)) dut (
    .n_clk(n_clk),
    .rst  (rst),
    .c    (c),
    .a    (a),
    .m    (m),
    .SDI  (SDI),
    .s    (s),
    .t    (t),
    .n    (n),
    .SDO  (SDO)
  );

  initial n_clk = 1'b0;
  always #5 n_clk = ~n_clk;

`ifdef C4_SAT_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  // Expected {cnt, s, t, n, SDO} from the model
  function automatic logic [W+3:0] exp_vec();
    logic [W-1:0] cv;
    logic         sdo;
    cv  = W'(mcnt);
    sdo = SCAN ? (((mcnt >> (W - 1)) & 1) != 0) : 1'b0;
    return {cv, (mcnt >= TH), mt, (mcnt == 0), sdo};
  endfunction

  // One clock edge: drive inputs, let the edge happen, advance the model
  task automatic step(input bit ci, input bit ai, input bit mi, input bit di);
    int prev;
    c = ci; a = ai; m = mi; SDI = di;
    @(posedge n_clk);
    if (!ci) begin
      mt = 1'b0;
    end else if (SCAN && !mi) begin
      mcnt = (mcnt * 2 + int'(di)) % (1 << W);
      mt   = 1'b0;
    end else begin
      prev = mcnt;
      mcnt = ai ? ((prev + 1 > MX) ? MX : prev + 1) : 0;
      if (ai && prev > MX) mcnt = MX;
      mt   = (prev < MX) && (mcnt == MX);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; c = 1'($urandom); a = 1'($urandom); m = 1'($urandom); SDI = 1'($urandom);
    #3;
    mcnt = 0; mt = 1'b0;
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || {s, t, n, SDO} !== 4'b0010) begin
      errors++;
      $display("FAIL reset: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
    @(posedge n_clk); #1;
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_held: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    logic [W-1:0] want [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    bit           twant[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0);
      vectors++;
      if ({dut.cnt, s, t, n, SDO} !== exp_vec() || dut.cnt !== want[i] || t !== twant[i]) begin
        errors++;
        $display("FAIL saturation edge%0d: got %b exp %b", i + 1, {dut.cnt, s, t, n, SDO}, exp_vec());
      end
    end
    step(1, 0, 1, 0);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || n !== 1'b1) begin
      errors++;
      $display("FAIL saturation_clear: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
  endtask

  task automatic test_scan();
    step(1, 1, 0, 1);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec()) begin
      errors++;
      $display("FAIL scan_shift1: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
    step(1, 1, 0, 1);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || SDO !== SCAN) begin
      errors++;
      $display("FAIL scan_shift2: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
    step(1, 1, 1, 0);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || dut.cnt !== W'(MX)) begin
      errors++;
      $display("FAIL scan_clamp: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
  endtask

  task automatic test_enable();
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      vectors++;
      if ({dut.cnt, s, t, n, SDO} !== exp_vec() || dut.cnt !== W'(1)) begin
        errors++;
        $display("FAIL enable_hold%0d: got %b exp %b", i, {dut.cnt, s, t, n, SDO}, exp_vec());
      end
    end
    step(1, 1, 1, 0);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || t !== 1'b1) begin
      errors++;
      $display("FAIL enable_resume: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    #3;
    rst = 1'b0;
    #1;
    mcnt = 0; mt = 1'b0;
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || n !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
    rst = 1'b1;
    step(1, 1, 1, 0);
    vectors++;
    if ({dut.cnt, s, t, n, SDO} !== exp_vec() || dut.cnt !== W'(1)) begin
      errors++;
      $display("FAIL async_reset_resume: got %b exp %b", {dut.cnt, s, t, n, SDO}, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) != 0), 1'($urandom));
      vectors++;
      if ({dut.cnt, s, t, n, SDO} !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got %b exp %b", i, {dut.cnt, s, t, n, SDO}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_scan();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/c4_sat.md
C4_SAT -- requirements
Module: c4_sat

Interface
REQ-001 Parameter WIDTH, default 2: counter/scan-chain width in bits, legal range 1..16.
REQ-002 Parameter MAX, default 2: saturation value; SHALL satisfy 1 <= MAX <= 2**WIDTH-1, else elaboration error.
REQ-003 Parameter THRESH, default 1: level at which s asserts; SHALL satisfy 1 <= THRESH <= MAX, else elaboration error.
REQ-004 n_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 c  input  1  clock enable; 0 = hold all state.
REQ-007 a  input  1  functional data input; 1 = advance run count, 0 = clear.
REQ-008 m  input  1  mode select; 1 = functional, 0 = scan shift.
REQ-009 SDI  input  1  scan serial data in, shifted into counter LSB.
REQ-010 s  output  1  count >= THRESH (combinational from state).
REQ-011 t  output  1  registered one-cycle pulse on reaching MAX.
REQ-012 n  output  1  count == 0 (combinational from state).
REQ-013 SDO  output  1  scan serial data out = counter MSB, in both modes.

Function
REQ-014 State SHALL be a WIDTH-bit register cnt plus a 1-bit register t; no other state.
REQ-015 Priority per edge SHALL be: rst low > c=0 (hold) > m=0 (scan) > m=1 (functional).
REQ-016 c=0: cnt holds; t SHALL clear to 0.
REQ-017 Scan (c=1, m=0): cnt <= {cnt[WIDTH-2:0], SDI} (for WIDTH=1, cnt <= SDI); t <= 0.
REQ-018 Functional, a=0: cnt <= 0.
REQ-019 Functional, a=1, cnt < MAX: cnt <= cnt + 1.
REQ-020 Functional, a=1, cnt >= MAX: cnt <= MAX (saturate; values above MAX, reachable only via scan, clamp to MAX in one cycle).
REQ-021 t SHALL be 1 in the cycle after a functional edge where cnt < MAX and next cnt == MAX; otherwise 0.
REQ-022 Sustained a=1 at saturation SHALL NOT retrigger t; a fresh pulse SHALL occur only after cnt drops below MAX and rises again.
REQ-023 Counter arithmetic SHALL NOT wrap; no path from 2**WIDTH-1 to 0 except a=0, scan or reset.
REQ-024 Mode change m 1->0 or 0->1 SHALL take effect on the same edge; cnt contents SHALL be preserved across the switch.
REQ-025 s, n, SDO SHALL be combinational decodes of cnt only, with no dependence on a, m or c.

Reset
REQ-026 rst low SHALL immediately (no clock) force cnt = 0, t = 0; hence s = 0, n = 1, SDO = 0.
REQ-027 Reset asserted mid-count or mid-shift SHALL discard the operation; the first update after rst rises SHALL occur on the next rising n_clk edge.

Configuration
REQ-028 Macro C4_SAT_SCAN_EN defined: scan path per REQ-017 present and SDO = cnt[WIDTH-1].
REQ-029 C4_SAT_SCAN_EN undefined: m and SDI ignored (always functional), SDO tied 0, no scan mux in the netlist; all other behaviour unchanged.

Verification (defaults WIDTH=2, MAX=2, THRESH=1, C4_SAT_SCAN_EN defined)
REQ-030 Reset: rst=0 with arbitrary inputs -> cnt=00, s=0, t=0, n=1, SDO=0 before any clock edge.
REQ-031 Saturation: m=1, c=1, a=1 for 4 edges -> cnt 01,10,10,10; s=1 from edge 1; t=1 only after edge 2; a=0 one edge -> cnt=00, n=1.
REQ-032 Scan: m=0, SDI 1,1 -> cnt 01,11, SDO=1 after edge 2; then m=1, a=1 -> cnt clamps to 10, t=0 (no pulse, since cnt was not below MAX).
REQ-033 Enable: cnt=01, c=0, a=1 for 3 edges -> cnt stays 01, t=0; c=1 -> cnt=10, t=1 next cycle.
REQ-034 Async reset mid-count: cnt=10, rst low between edges -> cnt=00, n=1 immediately; rst high then a=1 -> cnt=01 on the next edge.
REQ-035 Build without C4_SAT_SCAN_EN: m=0, SDI=1, a=1 for 2 edges -> cnt 01,10 (functional), SDO=0 throughout.
